// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS control FSM with memory-ready stalls
module multi_cycle_ctrl #(
    parameter int unsigned         OPCODE_W = 6,
    parameter int unsigned         STATE_W  = 4,
    parameter logic [OPCODE_W-1:0] OP_RTYPE = 6'h00,
    parameter logic [OPCODE_W-1:0] OP_LW    = 6'h23,
    parameter logic [OPCODE_W-1:0] OP_SW    = 6'h2B,
    parameter logic [OPCODE_W-1:0] OP_BEQ   = 6'h04,
    parameter logic [OPCODE_W-1:0] OP_J     = 6'h02,
    parameter logic [OPCODE_W-1:0] OP_ADDI  = 6'h08
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic [1:0]          pc_source_o,
    output logic                i_or_d_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic                reg_dst_o,
    output logic                mem_to_reg_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [1:0]          alu_op_o,
    output logic                inst_done_o,
    output logic                illegal_op_o,
    output logic [STATE_W-1:0]  state_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    // Moore portion of the controls, plus state flags used for the few
    // outputs that must also follow mem_ready or the opcode combinationally.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       inst_done;
        logic       in_fetch;
        logic       in_decode;
        logic       in_memwr;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   op_legal;
    logic   decode_illegal;

    function automatic ctrl_t decode_state(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.in_fetch  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.in_decode = 1'b1;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.inst_done  = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
                c.in_memwr  = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.inst_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.inst_done     = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                c.inst_done = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
                c.inst_done = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    assign op_legal = (opcode_i == OP_RTYPE) || (opcode_i == OP_LW)  ||
                      (opcode_i == OP_SW)    || (opcode_i == OP_BEQ) ||
                      (opcode_i == OP_J)     || (opcode_i == OP_ADDI);

    // Next-state selection; stall states wait on mem_ready, DECODE dispatches on opcode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_FETCH;
                if (opcode_i == OP_RTYPE)
                    state_d = S_EXEC;
                else if ((opcode_i == OP_LW) || (opcode_i == OP_SW))
                    state_d = S_MEMADR;
                else if (opcode_i == OP_BEQ)
                    state_d = S_BRANCH;
                else if (opcode_i == OP_J)
                    state_d = S_JUMP;
                else if (opcode_i == OP_ADDI)
                    state_d = S_ADDIEX;
            end
            S_MEMADR: state_d = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Controls are decoded from the upcoming state so they arrive registered with it.
    always_comb begin
        ctrl_d = decode_state(state_d);
    end

    // State and control registers; reset drops straight to IDLE with every control low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign decode_illegal  = ctrl_q.in_decode & ~op_legal;

    assign pc_write_o      = ctrl_q.pc_write | (ctrl_q.in_fetch & mem_ready_i);
    assign pc_write_cond_o = ctrl_q.pc_write_cond;
    assign pc_source_o     = ctrl_q.pc_source;
    assign i_or_d_o        = ctrl_q.i_or_d;
    assign mem_read_o      = ctrl_q.mem_read;
    assign mem_write_o     = ctrl_q.mem_write;
    assign ir_write_o      = ctrl_q.in_fetch & mem_ready_i;
    assign reg_dst_o       = ctrl_q.reg_dst;
    assign mem_to_reg_o    = ctrl_q.mem_to_reg;
    assign reg_write_o     = ctrl_q.reg_write;
    assign alu_src_a_o     = ctrl_q.alu_src_a;
    assign alu_src_b_o     = ctrl_q.alu_src_b;
    assign alu_op_o        = ctrl_q.alu_op;
    assign inst_done_o     = ctrl_q.inst_done | (ctrl_q.in_memwr & mem_ready_i) | decode_illegal;
    assign illegal_op_o    = decode_illegal;
    assign state_o         = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, inst_done, illegal_op;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;

    multi_cycle_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .opcode_i        (opcode),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .pc_source_o     (pc_source),
        .i_or_d_o        (i_or_d),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .reg_dst_o       (reg_dst),
        .mem_to_reg_o    (mem_to_reg),
        .reg_write_o     (reg_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .inst_done_o     (inst_done),
        .illegal_op_o    (illegal_op),
        .state_o         (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       inst_done;
        logic       illegal_op;
    } ov_t;

    typedef struct { logic mr; logic [5:0] op; } stim_t;
    typedef struct { int st; ov_t ov; } exp_t;
    typedef struct { logic [5:0] op; int fw; int mw; int cpi; } vec_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    cpi_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int since = 0;
    int done_cnt = 0;
    int insts = 0;

    function automatic logic is_legal(logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
               (op == 6'h04) || (op == 6'h02) || (op == 6'h08);
    endfunction

    function automatic ov_t exp_out(int st, logic mr, logic [5:0] op);
        ov_t o;
        o = '0;
        case (st)
            1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
            2:  begin o.alu_src_b = 2'b11; o.illegal_op = !is_legal(op); o.inst_done = !is_legal(op); end
            3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4:  begin o.mem_read = 1; o.i_or_d = 1; end
            5:  begin o.reg_write = 1; o.mem_to_reg = 1; o.inst_done = 1; end
            6:  begin o.mem_write = 1; o.i_or_d = 1; o.inst_done = mr; end
            7:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            8:  begin o.reg_write = 1; o.reg_dst = 1; o.inst_done = 1; end
            9:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; o.inst_done = 1; end
            10: begin o.pc_write = 1; o.pc_source = 2'b10; o.inst_done = 1; end
            11: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            12: begin o.reg_write = 1; o.inst_done = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic ov_t actual_out();
        return {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, inst_done, illegal_op};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(int st, logic mr, logic [5:0] op);
        stim_t s;
        exp_t  e;
        s.mr = mr;
        s.op = op;
        e.st = st;
        e.ov = exp_out(st, mr, op);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic gen_inst(logic [5:0] op, int fw, int mw, int cpi);
        for (int i = 0; i < fw; i++) push(1, 1'b0, 6'($urandom));
        push(1, 1'b1, 6'($urandom));
        push(2, 1'($urandom), op);
        case (op)
            6'h00: begin push(7, 1'($urandom), op); push(8, 1'($urandom), op); end
            6'h23: begin
                push(3, 1'($urandom), op);
                for (int i = 0; i < mw; i++) push(4, 1'b0, op);
                push(4, 1'b1, op);
                push(5, 1'($urandom), op);
            end
            6'h2B: begin
                push(3, 1'($urandom), op);
                for (int i = 0; i < mw; i++) push(6, 1'b0, op);
                push(6, 1'b1, op);
            end
            6'h04: push(9, 1'($urandom), op);
            6'h02: push(10, 1'($urandom), op);
            6'h08: begin push(11, 1'($urandom), op); push(12, 1'($urandom), op); end
            default: ;
        endcase
        cpi_q.push_back(cpi);
        insts++;
    endtask

    // Drive one queued cycle after each rising edge, compare at the falling edge.
    task automatic run_queue();
        while (stim_q.size() > 0) begin
            stim_t s;
            exp_t  e;
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            mem_ready = s.mr;
            opcode    = s.op;
            @(negedge clk);
            cyc++;
            since++;
            check($sformatf("state@%0d", cyc), 32'(state), 32'(e.st));
            check($sformatf("outputs@%0d st=%0d", cyc, e.st), 32'(actual_out()), 32'(e.ov));
            if (inst_done) begin
                done_cnt++;
                if (cpi_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_inst_done@%0d: got 1 expected 0", cyc);
                end else begin
                    check($sformatf("cpi@%0d", cyc), 32'(since), 32'(cpi_q.pop_front()));
                end
                since = 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{6'h00, 0, 0, 4};
        vecs[1]  = '{6'h23, 0, 2, 7};
        vecs[2]  = '{6'h2B, 0, 0, 4};
        vecs[3]  = '{6'h04, 0, 0, 3};
        vecs[4]  = '{6'h02, 0, 0, 3};
        vecs[5]  = '{6'h08, 0, 0, 4};
        vecs[6]  = '{6'h3F, 0, 0, 2};
        vecs[7]  = '{6'h00, 1, 0, 5};
        vecs[8]  = '{6'h2B, 0, 1, 5};
        vecs[9]  = '{6'h08, 2, 0, 6};
        vecs[10] = '{6'h23, 1, 0, 6};

        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'h00;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_outputs", 32'(actual_out()), 32'(exp_out(0, 1'b1, 6'h00)));
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) gen_inst(vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].cpi);
        run_queue();

        // sw stalled in MEMWR, then reset asserted asynchronously mid-cycle
        push(1, 1'b1, 6'h11);
        push(2, 1'b1, 6'h2B);
        push(3, 1'b1, 6'h2B);
        push(6, 1'b0, 6'h2B);
        run_queue();
        rst_n = 1'b0;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_outputs", 32'(actual_out()), 32'(exp_out(0, 1'b0, 6'h2B)));
        @(posedge clk);
        #1;
        check("abort_held_state", 32'(state), 32'd0);
        check("abort_held_outputs", 32'(actual_out()), 32'(exp_out(0, 1'b0, 6'h2B)));
        @(negedge clk);
        rst_n = 1'b1;
        since = 0;
        gen_inst(6'h00, 0, 0, 4);
        run_queue();

        check("inst_done_total", 32'(done_cnt), 32'(insts));
        check("cpi_left", 32'(cpi_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
